usb_data_buffer: RTL and testbench

Shared 64-byte FIFO between the AHB-Lite slave and the USB packet engines. Accepts bytes from the AHB slave (`store_tx_data`/`tx_data`) and from the USB RX engine, and delivers them in order to the USB TX engine or back to the AHB slave. It reports `buffer_occupancy` to the slave's occupancy register and honours the slave's `clear` (flush) request.

---
 rtl/usb_buf_pkg.sv | 6 +
 rtl/buf_regfile.sv | 25 ++
 rtl/usb_data_buffer.sv | 90 +++++++++
 tb/tb_usb_data_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_buf_pkg.sv
// Shared constants for the USB data buffer and the AHB slave that reads its occupancy.
package usb_buf_pkg;
   localparam int BUF_DEPTH = 64;
   localparam int PTR_W     = 6;
   localparam int OCC_W     = 7;
endpackage

// File: rtl/buf_regfile.sv
// Byte register file: one synchronous write port, one asynchronous read port, no reset.
module buf_regfile
   import usb_buf_pkg::*;
#(
   parameter int DEPTH = BUF_DEPTH,
   parameter int AW    = PTR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Write the addressed byte on the rising edge; contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the AHB slave and the USB packet engines.
// Handshake: push and pop are single-cycle strobes with no back-pressure; a push
// that cannot be stored is dropped and latches overflow, a pop on an empty buffer
// is ignored and latches underflow. Head outputs are first-word fall-through.
module usb_data_buffer
   import usb_buf_pkg::*;
#(
   parameter int DEPTH = BUF_DEPTH,
   parameter int OCC_W = $clog2(BUF_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             store_tx_data,
   input  logic [7:0]       tx_data,
   input  logic             get_tx_packet_data,
   output logic [7:0]       tx_packet_data,
   input  logic             store_rx_packet_data,
   input  logic [7:0]       rx_packet_data,
   input  logic             get_rx_data,
   output logic [7:0]       rx_data,
   output logic [OCC_W-1:0] buffer_occupancy,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [7:0]       head_byte;

   logic push, pop, full, empty, collide;
   logic push_ok, pop_ok, drop_full;
   logic [7:0] push_data;

   assign push      = store_tx_data | store_rx_packet_data;
   assign pop       = get_tx_packet_data | get_rx_data;
   assign collide   = store_tx_data & store_rx_packet_data;
   assign push_data = store_tx_data ? tx_data : rx_packet_data;

   assign full      = (occ == OCC_W'(DEPTH));
   assign empty     = (occ == '0);

   // A pop succeeds whenever something is stored; a push succeeds unless the
   // buffer is full, and even then a same-cycle pop frees the slot being written.
   assign pop_ok    = pop & ~empty;
   assign push_ok   = push & (~full | pop_ok);
   assign drop_full = push & full & ~pop;

   buf_regfile #(.DEPTH(DEPTH), .AW(AW)) u_regfile (
      .clk   (clk),
      .we    (push_ok & ~clear),
      .waddr (wr_ptr),
      .wdata (push_data),
      .raddr (rd_ptr),
      .rdata (head_byte)
   );

   // Pointers, occupancy and sticky flags; clear overrides every other request.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok)      occ <= occ + OCC_W'(1);
         else if (pop_ok && !push_ok) occ <= occ - OCC_W'(1);
         if (drop_full || collide) overflow  <= 1'b1;
         if (pop && empty)         underflow <= 1'b1;
      end
   end

   // Stale memory is never visible: the head reads zero while empty.
   assign tx_packet_data   = empty ? 8'h00 : head_byte;
   assign rx_data          = empty ? 8'h00 : head_byte;
   assign buffer_occupancy = occ;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer with a byte-order scoreboard.
module tb_usb_data_buffer;
   import usb_buf_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   logic             clear = 1'b0;
   logic             store_tx_data = 1'b0;
   logic [7:0]       tx_data = 8'h00;
   logic             get_tx_packet_data = 1'b0;
   logic [7:0]       tx_packet_data;
   logic             store_rx_packet_data = 1'b0;
   logic [7:0]       rx_packet_data = 8'h00;
   logic             get_rx_data = 1'b0;
   logic [7:0]       rx_data;
   logic [OCC_W-1:0] buffer_occupancy;
   logic             overflow;
   logic             underflow;

   usb_data_buffer dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .clear                (clear),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .tx_packet_data       (tx_packet_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_rx_data          (get_rx_data),
      .rx_data              (rx_data),
      .buffer_occupancy     (buffer_occupancy),
      .overflow             (overflow),
      .underflow            (underflow)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drive one cycle of requests just after an edge, hold across the next edge,
   // then return 1 time unit after that edge with all strobes low.
   task automatic cyc(input logic s_tx, input logic [7:0] d_tx,
                      input logic s_rx, input logic [7:0] d_rx,
                      input logic g_tx, input logic g_rx, input logic clr);
      store_tx_data        = s_tx;
      tx_data              = d_tx;
      store_rx_packet_data = s_rx;
      rx_packet_data       = d_rx;
      get_tx_packet_data   = g_tx;
      get_rx_data          = g_rx;
      clear                = clr;
      @(posedge clk);
      #1;
      store_tx_data        = 1'b0;
      store_rx_packet_data = 1'b0;
      get_tx_packet_data   = 1'b0;
      get_rx_data          = 1'b0;
      clear                = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] b);
      cyc(1'b1, b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(b);
   endtask

   task automatic push_rx(input logic [7:0] b);
      cyc(1'b0, 8'h00, 1'b1, b, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(b);
   endtask

   // Check the head against the oldest expected byte, then pop it.
   task automatic pop_chk(input string tag, input logic g_tx, input logic g_rx);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_q_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_tx"}, 32'(tx_packet_data), 32'(e));
         chk({tag, "_rx"}, 32'(rx_data), 32'(e));
      end
      cyc(1'b0, 8'h00, 1'b0, 8'h00, g_tx, g_rx, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_occ", 32'(buffer_occupancy), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);
      chk("rst_tx", 32'(tx_packet_data), 32'h00);
      chk("rst_rx", 32'(rx_data), 32'h00);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // single byte fall-through and pop
      push_tx(8'hA5);
      chk("one_occ", 32'(buffer_occupancy), 32'd1);
      pop_chk("one_head", 1'b1, 1'b0);
      chk("one_occ0", 32'(buffer_occupancy), 32'd0);
      chk("one_tx0", 32'(tx_packet_data), 32'h00);

      // fill to 64, overflow on the 65th, drain in order
      for (int i = 0; i < 64; i++) push_tx(8'(i));
      chk("full_occ", 32'(buffer_occupancy), 32'd64);
      chk("full_ovf0", 32'(overflow), 32'd0);
      cyc(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("ovf_occ", 32'(buffer_occupancy), 32'd64);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 64; i++) pop_chk("drain", 1'b1, 1'b0);
      chk("drain_occ", 32'(buffer_occupancy), 32'd0);
      chk("drain_tx0", 32'(tx_packet_data), 32'h00);
      chk("drain_ovf_sticky", 32'(overflow), 32'd1);
      chk("drain_udf", 32'(underflow), 32'd0);

      // push and pop together while full
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clr_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 64; i++) push_tx(8'h80 + 8'(i));
      chk("full2_occ", 32'(buffer_occupancy), 32'd64);
      chk("pp_head", 32'(tx_packet_data), 32'h80);
      void'(exp_q.pop_front());
      exp_q.push_back(8'h77);
      cyc(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("pp_occ", 32'(buffer_occupancy), 32'd64);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_next", 32'(tx_packet_data), 32'h81);
      for (int i = 0; i < 64; i++) pop_chk("pp_drain", 1'b1, 1'b0);
      chk("pp_occ0", 32'(buffer_occupancy), 32'd0);

      // both stores at once: TX byte kept, RX byte dropped, overflow set
      cyc(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      chk("col_occ", 32'(buffer_occupancy), 32'd1);
      chk("col_head", 32'(rx_data), 32'h3C);
      chk("col_ovf", 32'(overflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("col_occ0", 32'(buffer_occupancy), 32'd0);

      // underflow, then clear drops both flags
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("udf_flag", 32'(underflow), 32'd1);
      chk("udf_occ", 32'(buffer_occupancy), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clr_udf", 32'(underflow), 32'd0);
      chk("clr_ovf2", 32'(overflow), 32'd0);

      // clear beats a same-cycle push
      for (int i = 0; i < 10; i++) push_tx(8'h10 + 8'(i));
      chk("ten_occ", 32'(buffer_occupancy), 32'd10);
      exp_q.delete();
      cyc(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clrp_occ", 32'(buffer_occupancy), 32'd0);
      chk("clrp_tx", 32'(tx_packet_data), 32'h00);
      chk("clrp_rx", 32'(rx_data), 32'h00);
      chk("clrp_ovf", 32'(overflow), 32'd0);
      push_tx(8'h12);
      chk("clrp_occ1", 32'(buffer_occupancy), 32'd1);
      pop_chk("clrp_head", 1'b1, 1'b0);

      // pointer wrap: 60 in/out, then 8 RX-path bytes straddling 63->0
      for (int i = 0; i < 60; i++) push_tx(8'h20 + 8'(i));
      for (int i = 0; i < 60; i++) pop_chk("w60", 1'b1, 1'b1);
      chk("w60_occ", 32'(buffer_occupancy), 32'd0);
      for (int i = 0; i < 8; i++) push_rx(8'hD0 + 8'(i));
      chk("wrap_occ", 32'(buffer_occupancy), 32'd8);
      for (int i = 0; i < 8; i++) pop_chk("wrap", 1'b0, 1'b1);
      chk("wrap_occ0", 32'(buffer_occupancy), 32'd0);
      chk("wrap_udf", 32'(underflow), 32'd0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) push_tx(8'hE0 + 8'(i));
      chk("pre_rst_occ", 32'(buffer_occupancy), 32'd3);
      store_tx_data = 1'b1;
      tx_data = 8'hEE;
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst_occ", 32'(buffer_occupancy), 32'd0);
      chk("arst_tx", 32'(tx_packet_data), 32'h00);
      chk("arst_ovf", 32'(overflow), 32'd0);
      store_tx_data = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_hold_occ", 32'(buffer_occupancy), 32'd0);
      n_rst = 1'b1;

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      total++;
      bad++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
